lcd_write_arbiter: RTL

//  Shares the single character-write port of the lcd controller between two requesters:
//  req0 = processor LCD output, req1 = status/debug message source.

---
 rtl/lcd_write_arbiter_pkg.sv | 18 +
 rtl/lcd_req_fifo.sv | 45 ++++
 rtl/lcd_write_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lcd_write_arbiter_pkg.sv
// Shared definitions for the LCD write arbiter: FSM encoding, default widths and timing.
package lcd_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } lcd_state_t;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2000;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Small synchronous FIFO holding {last,data} entries for one requester.
module lcd_req_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head      = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin, message-locked arbiter sharing the LCD character-write port between two
// requesters, with enforced spacing between write strobes and a lock timeout.
module lcd_write_arbiter
  import lcd_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              lcd_write_en,
  output logic [DATA_W-1:0] lcd_write_data,
  output logic [1:0]        grant,
  output logic              lock_err,
  output lcd_state_t        dbg_state
);

  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

  logic              w_full0, w_empty0, w_full1, w_empty1;
  logic [DATA_W:0]   w_head0, w_head1, w_head;
  logic              w_pop0, w_pop1;
  logic              w_owner_empty, w_any, w_sel;

  lcd_state_t        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_lock, w_lock_nxt;
  logic              r_last_served, w_last_nxt;
  logic              r_lock_err, w_err_nxt;
  logic              r_wen, w_wen_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

  lcd_req_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clock (clock), .resetn (resetn),
    .push  (req0_valid), .din ({req0_last, req0_data}), .pop (w_pop0),
    .full  (w_full0), .empty (w_empty0), .head (w_head0)
  );

  lcd_req_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clock (clock), .resetn (resetn),
    .push  (req1_valid), .din ({req1_last, req1_data}), .pop (w_pop1),
    .full  (w_full1), .empty (w_empty1), .head (w_head1)
  );

  assign w_head        = r_owner ? w_head1 : w_head0;
  assign w_owner_empty = r_owner ? w_empty1 : w_empty0;
  assign w_any         = ~w_empty0 | ~w_empty1;
  // When both wait, the requester not served last wins.
  assign w_sel         = w_empty0 ? 1'b1 : (w_empty1 ? 1'b0 : ~r_last_served);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_lock_nxt  = r_lock;
    w_last_nxt  = r_last_served;
    w_err_nxt   = r_lock_err;
    w_wen_nxt   = 1'b0;
    w_wdata_nxt = r_wdata;
    w_pop0      = 1'b0;
    w_pop1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_sel;
          w_grant_nxt = owner_onehot(w_sel);
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_pop0      = ~r_owner;
        w_pop1      = r_owner;
        w_wen_nxt   = 1'b1;
        w_wdata_nxt = w_head[DATA_W-1:0];
        w_lock_nxt  = ~w_head[DATA_W];
        if (w_head[DATA_W]) w_last_nxt = r_owner;
        w_cnt_nxt   = GAP_LOAD;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!r_lock) begin
          // Re-arbitrate immediately so waiting data keeps the exact strobe spacing.
          if (w_any) begin
            w_owner_nxt = w_sel;
            w_grant_nxt = owner_onehot(w_sel);
            w_state_nxt = ST_SEND;
          end else begin
            w_grant_nxt = 2'b00;
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_owner_empty) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_owner_empty) begin
          w_state_nxt = ST_SEND;
        end else if (r_cnt == '0) begin
          w_err_nxt   = 1'b1;
          w_last_nxt  = r_owner;
          w_lock_nxt  = 1'b0;
          w_grant_nxt = 2'b00;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_grant       <= 2'b00;
      r_cnt         <= '0;
      r_lock        <= 1'b0;
      r_last_served <= 1'b1;
      r_lock_err    <= 1'b0;
      r_wen         <= 1'b0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_grant       <= w_grant_nxt;
      r_cnt         <= w_cnt_nxt;
      r_lock        <= w_lock_nxt;
      r_last_served <= w_last_nxt;
      r_lock_err    <= w_err_nxt;
      r_wen         <= w_wen_nxt;
      r_wdata       <= w_wdata_nxt;
    end
  end

  assign req0_ready     = ~w_full0;
  assign req1_ready     = ~w_full1;
  assign lcd_write_en   = r_wen;
  assign lcd_write_data = r_wdata;
  assign grant          = r_grant;
  assign lock_err       = r_lock_err;
  assign dbg_state      = r_state;

endmodule
